divider_unit: RTL and testbench

- Multicycle RV32M divide responder: the far end of the div_valid/div_ready handshake that the control unit drives.
- Executes DIV, DIVU, REM and REMU on latched operands with a radix-2 restoring algorithm, one quotient bit per cycle.
- Sits in the datapath beside the multiplier; its result feeds the result mux.
- Divide-by-zero and signed overflow complete on a fast path.

---
 rtl/divider_unit.sv | 137 +++++++++++++
 tb/tb_divider_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// divider_unit: multicycle RV32M divide (DIV/DIVU/REM/REMU).
// Radix-2 restoring divide on latched magnitudes, one quotient bit per cycle,
// with a sign-fix cycle at the end. Divide-by-zero and signed overflow
// complete directly from IDLE.
module divider_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            div_valid,
  input  logic [1:0]      DIVop,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            div_ready,
  output logic [XLEN-1:0] div_result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   diff;
  logic              borrow;

  // Next-state and datapath for all four states
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;

    // Magnitudes are taken only for signed ops (DIVop[0]==0)
    a_neg  = ~DIVop[0] & dividend[XLEN-1];
    b_neg  = ~DIVop[0] & divisor[XLEN-1];
    a_abs  = a_neg ? (~dividend + 1'b1) : dividend;
    b_abs  = b_neg ? (~divisor + 1'b1) : divisor;

    // Trial subtract on the shifted partial remainder; the shifted value can
    // exceed XLEN bits, so compare one bit wider and look at the borrow.
    // Bit XLEN of diff is zero whenever there is no borrow.
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
    borrow = |diff[XLEN+1:XLEN];

    unique case (state_q)
      IDLE: begin
        if (div_valid) begin
          op_d   = DIVop;
          dvs_d  = b_abs;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (divisor == '0) begin
            res_d   = DIVop[1] ? dividend : '1;
            state_d = DONE;
          end else if (!DIVop[0] && dividend == {1'b1, {(XLEN-1){1'b0}}} &&
                       divisor == '1) begin
            res_d   = DIVop[1] ? '0 : dividend;
            state_d = DONE;
          end else begin
            quo_d   = a_abs;
            rem_d   = '0;
            cnt_d   = CW'(XLEN-1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!borrow) begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        // Sign flags were only set for signed ops, so unsigned passes through
        if (op_q[1]) res_d = rneg_q ? (~rem_q + 1'b1) : rem_q;
        else         res_d = qneg_q ? (~quo_q + 1'b1) : quo_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
    end
  end

  assign div_ready  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign div_result = res_q;

endmodule

// File: tb/tb_divider_unit.sv
// Directed bench for divider_unit with an expected-result scoreboard.
module tb_divider_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_valid;
  logic [1:0]  DIVop;
  logic [31:0] dividend, divisor;
  logic        div_ready;
  logic [31:0] div_result;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   passes = 0;
  int   total  = 0;
  int   pulses = 0;

  divider_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .DIVop      (DIVop),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_result (div_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (div_ready) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Called just after the start edge; n = edges from start (inclusive) until
  // div_ready is visible.
  task automatic wait_ready(output int n);
    n = 1;
    @(negedge clk);
    while (!div_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pop_check(input string tag, input int n);
    exp_t e;
    e = sb.pop_front();
    check({tag, " result"}, div_result, e.res);
    check({tag, " latency"}, 32'(n), 32'(e.lat));
  endtask

  // One operation; operands and opcode are scrambled right after the start edge.
  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    int p0;
    @(negedge clk);
    DIVop = op; dividend = a; divisor = b; div_valid = 1'b1;
    sb.push_back('{exp, lat});
    p0 = pulses;
    @(posedge clk); #1;
    div_valid = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    DIVop     = 2'($urandom);
    wait_ready(n);
    pop_check(tag, n);
    @(negedge clk);
    check({tag, " ready one cycle"}, {31'b0, div_ready}, 32'd0);
    check({tag, " pulse count"}, 32'(pulses - p0), 32'd1);
  endtask

  initial begin
    int n;
    int p0;
    reset = 1'b1; div_valid = 1'b0; DIVop = 2'b00; dividend = '0; divisor = '0;
    #12;
    check("reset ready", {31'b0, div_ready}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset result", div_result, 32'd0);
    @(negedge clk); reset = 1'b0;

    run("DIV 100/7",   2'b00, 32'd100, 32'd7, 32'd14, 34);
    run("REM 100/7",   2'b10, 32'd100, 32'd7, 32'd2, 34);
    run("DIV -7/2",    2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    run("REM -7/2",    2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    run("DIV 7/-2",    2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    run("REM 7/-2",    2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 34);
    run("DIVU max/1",  2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 34);
    run("REMU max/16", 2'b11, 32'hFFFFFFFF, 32'd16, 32'hF, 34);
    run("DIV /0",      2'b00, 32'h1234, 32'd0, 32'hFFFFFFFF, 1);
    run("DIVU /0",     2'b01, 32'h1234, 32'd0, 32'hFFFFFFFF, 1);
    run("REM /0",      2'b10, 32'h1234, 32'd0, 32'h1234, 1);
    run("REMU /0",     2'b11, 32'h1234, 32'd0, 32'h1234, 1);
    run("DIV ovf",     2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("REM ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    run("DIVU ovf",    2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34);
    run("REMU ovf",    2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);

    // Reset abort ten cycles into a DIV
    @(negedge clk);
    DIVop = 2'b00; dividend = 32'd100; divisor = 32'd7; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    p0 = pulses;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort result", div_result, 32'd0);
    check("abort ready", {31'b0, div_ready}, 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort no pulse", 32'(pulses - p0), 32'd0);
    run("DIVU 9/3", 2'b01, 32'd9, 32'd3, 32'd3, 34);

    // Back-to-back with div_valid held: DIV 20/3 then REMU 20/3
    @(negedge clk);
    DIVop = 2'b00; dividend = 32'd20; divisor = 32'd3; div_valid = 1'b1;
    sb.push_back('{32'd6, 34});
    sb.push_back('{32'd2, 34});
    p0 = pulses;
    @(posedge clk); #1;
    DIVop = 2'b11;
    wait_ready(n);
    pop_check("b2b DIV", n);
    @(posedge clk);
    @(posedge clk); #1;
    div_valid = 1'b0;
    wait_ready(n);
    pop_check("b2b REMU", n);
    repeat (3) @(posedge clk);
    #1;
    check("b2b pulses", 32'(pulses - p0), 32'd2);
    check("b2b idle", {31'b0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
